// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART definitions (transmit FSM states, line levels).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/parity_generator.sv
// ============================================================================
// Module   : parity_generator
// Brief    : Combinational parity bit for one data byte, even or odd.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_generator (
    input  logic [7:0] i_data,
    input  logic       i_odd,
    output logic       o_parity
);

    // Same definition the receive checker uses: even = ^data, odd = ~^data.
    assign o_parity = (^i_data) ^ i_odd;

endmodule

`default_nettype wire

// File: rtl/uart_tx_parity.sv
// ============================================================================
// Module   : uart_tx_parity
// Brief    : UART transmitter, start + 8 data (LSB first) + parity + stop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_out
);

    localparam int                c_cnt_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        c_last_idx = 3'(DATA_BITS - 1);

    tx_state_t          r_state,  w_state_next;
    logic [c_cnt_w-1:0] r_cnt,    w_cnt_next;
    logic [2:0]         r_idx,    w_idx_next;
    logic [7:0]         r_shift,  w_shift_next;
    logic               r_parity, w_parity_next;
    logic               r_tx_out, w_tx_out_next;
    logic               r_busy,   w_busy_next;
    logic               r_done,   w_done_next;
    logic               w_parity_gen;
    logic               w_bit_end;

    parity_generator u_parity_generator (
        .i_data   (tx_data),
        .i_odd    (PARITY_ODD != 0),
        .o_parity (w_parity_gen)
    );

    assign w_bit_end = (r_cnt == c_cnt_max);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx_out <= IDLE_LVL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_idx    <= w_idx_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_tx_out <= w_tx_out_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt + 1'b1;
        w_idx_next    = r_idx;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_done_next   = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (tx_start) begin
                    w_state_next  = START;
                    w_shift_next  = tx_data;
                    w_parity_next = w_parity_gen;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_idx_next   = r_idx + 1'b1;
                    if (r_idx == c_last_idx) begin
                        w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next = STOP;
                    w_cnt_next   = '0;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase

        // Line level is derived from the next state so tx_out stays registered.
        case (w_state_next)
            START:   w_tx_out_next = START_LVL;
            DATA:    w_tx_out_next = w_shift_next[0];
            PARITY:  w_tx_out_next = w_parity_next;
            STOP:    w_tx_out_next = STOP_LVL;
            default: w_tx_out_next = IDLE_LVL;
        endcase

        w_busy_next = (w_state_next != IDLE);
    end

    assign tx_out  = r_tx_out;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_parity.sv
// ============================================================================
// Module   : tb_uart_tx_parity
// Brief    : Scoreboard bench for uart_tx_parity (even, odd, no-parity builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_parity;

    localparam int C = 4;

    typedef struct {
        int         id;
        logic [7:0] d;
        logic       p;
        logic       b2b;
    } exp_t;

    logic       clk;
    logic       RST;
    logic [2:0] start;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] line;
    logic [7:0] data [3];

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rst_prev = 1'b0;
    logic in_f [3];
    int   t0 [3];
    int   last_done [3];
    logic [7:0] cur_d [3];
    logic       cur_p [3];

    // dut 0: even parity, dut 1: odd parity, dut 2: no parity
    uart_tx_parity #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .CLK(clk), .RST(RST), .tx_data(data[0]), .tx_start(start[0]),
        .tx_busy(busy[0]), .tx_done(done[0]), .tx_out(line[0]));
    uart_tx_parity #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .CLK(clk), .RST(RST), .tx_data(data[1]), .tx_start(start[1]),
        .tx_busy(busy[1]), .tx_done(done[1]), .tx_out(line[1]));
    uart_tx_parity #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
        .CLK(clk), .RST(RST), .tx_data(data[2]), .tx_start(start[2]),
        .tx_busy(busy[2]), .tx_done(done[2]), .tx_out(line[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    function automatic int flen(input int k);
        return (k == 2) ? 10 * C : 11 * C;
    endfunction

    function automatic logic exp_bit(input int k, input int o);
        int b;
        b = o / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur_d[k][b-1];
        if (b == 9 && k != 2) return cur_p[k];
        return 1'b1;
    endfunction

    // Monitor: follows each serial line, pops the expected frame at its start bit.
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (rst_prev) begin
                chk("rst_line", k, line[k], 1);
                chk("rst_busy", k, busy[k], 0);
                chk("rst_done", k, done[k], 0);
                in_f[k] = 1'b0;
            end else if (!RST) begin
                in_f[k] = 1'b0;
            end else begin
                if (!in_f[k] && line[k] === 1'b0) begin
                    chk("frame_expected", k, (q.size() > 0 && q[0].id == k), 1);
                    if (q.size() > 0 && q[0].id == k) begin
                        exp_t e;
                        e = q.pop_front();
                        cur_d[k] = e.d;
                        cur_p[k] = e.p;
                        if (e.b2b) chk("b2b_gap", k, cyc - last_done[k], 1);
                        in_f[k] = 1'b1;
                        t0[k]   = cyc;
                    end
                end
                if (in_f[k]) begin
                    int o;
                    o = cyc - t0[k];
                    if (o < flen(k)) begin
                        chk("line_bit", k, line[k], exp_bit(k, o));
                        chk("busy_in_frame", k, busy[k], 1);
                        chk("done_in_frame", k, done[k], 0);
                    end else begin
                        chk("done_pulse", k, done[k], 1);
                        chk("busy_at_done", k, busy[k], 0);
                        chk("line_at_done", k, line[k], 1);
                        in_f[k]      = 1'b0;
                        last_done[k] = cyc;
                    end
                end else if (line[k] === 1'b1) begin
                    chk("idle_quiet", k, {busy[k], done[k]}, 0);
                end
            end
        end
        if (!RST) q.delete();
        rst_prev = !RST;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic p, input logic b2b);
        exp_t e;
        e.id = k; e.d = d; e.p = p; e.b2b = b2b;
        q.push_back(e);
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic p);
        int n;
        n = 0;
        while (busy[k] && n < 200) begin tick(); n++; end
        chk("send_wait_idle", k, busy[k], 0);
        start[k] = 1'b1;
        data[k]  = d;
        push(k, d, p, 1'b0);
        tick();
        start[k] = 1'b0;
        data[k]  = ~d;
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (!done[k] && n < 300) begin tick(); n++; end
        chk("done_wait", k, done[k], 1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_f[k] = 1'b0; t0[k] = 0; last_done[k] = -100;
            cur_d[k] = 8'h00; cur_p[k] = 1'b0; data[k] = 8'h00;
        end
        start = 3'b000;
        RST   = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        repeat (2) tick();

        // Even parity frames: A5 -> 0, 07 -> 1, F1 -> 1
        send(0, 8'hA5, 1'b0); wait_done(0); repeat (3) tick();
        send(0, 8'h07, 1'b1); wait_done(0); repeat (2) tick();
        send(0, 8'hF1, 1'b1); wait_done(0); repeat (2) tick();

        // Start request while busy is ignored
        send(0, 8'h3C, 1'b0);
        repeat (20) tick();
        start[0] = 1'b1; data[0] = 8'hFF;
        repeat (2) tick();
        start[0] = 1'b0;
        wait_done(0); repeat (5) tick();

        // Back-to-back with tx_start held high
        start[0] = 1'b1; data[0] = 8'h55; push(0, 8'h55, 1'b0, 1'b0);
        tick();
        data[0] = 8'h81; push(0, 8'h81, 1'b0, 1'b1);
        wait_done(0);
        tick();
        start[0] = 1'b0;
        wait_done(0); repeat (3) tick();

        // Reset during data bit 3, then a clean frame
        send(0, 8'hC3, 1'b0);
        repeat (17) tick();
        RST = 1'b0;
        tick();
        RST = 1'b1;
        repeat (2) tick();
        send(0, 8'h80, 1'b1); wait_done(0); repeat (2) tick();

        // Odd parity: 07 -> 0, A5 -> 1
        send(1, 8'h07, 1'b0); wait_done(1); repeat (2) tick();
        send(1, 8'hA5, 1'b1); wait_done(1); repeat (2) tick();

        // No parity slot
        send(2, 8'h00, 1'b0); wait_done(2); repeat (2) tick();
        send(2, 8'hA5, 1'b0); wait_done(2); repeat (3) tick();

        chk("queue_drained", 0, q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
